// File: rtl/alu_scheduler_pkg.sv
// Shared definitions for the ALU scheduler: op codes, FSM states and op decode helpers.
package alu_scheduler_pkg;

    localparam logic [2:0] ALU_AND    = 3'd0;
    localparam logic [2:0] ALU_OR     = 3'd1;
    localparam logic [2:0] ALU_XOR    = 3'd2;
    localparam logic [2:0] ALU_ADD    = 3'd3;
    localparam logic [2:0] ALU_NOT    = 3'd4;
    localparam logic [2:0] ALU_SUB    = 3'd5;
    localparam logic [2:0] ALU_OP_MAX = 3'd5;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    // Codes above the last real ALU function have no defined result.
    function automatic logic op_is_err(input logic [2:0] op);
        return op > ALU_OP_MAX;
    endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// Request (two requesters) and response channels of the ALU scheduler.
interface alu_scheduler_if #(
    parameter int unsigned DATA_W = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [2:0]        req0_op;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [2:0]        req1_op;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_carry;
    logic              rsp_err;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter; ptr picks the winner only when both request.
module alu_scheduler_rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (&req) begin
                gnt = ptr ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one combinational ALU between two requesters and returns results on a
// backpressured response channel; one op in flight at a time (IDLE -> EXEC -> RESP).
module alu_scheduler
    import alu_scheduler_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_L,
    alu_scheduler_if.slave    bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_select,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              carry_out,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    state_e            state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic              id_q, id_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_carry_q, rsp_carry_d;
    logic              rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       arb_en;
    logic       exec_err;

    assign req    = {bus.req1_valid, bus.req0_valid};
    assign arb_en = (state_q == StIdle);

    alu_scheduler_rr_arbiter2 u_arb (
        .req (req),
        .ptr (rr_ptr_q),
        .en  (arb_en),
        .gnt (gnt)
    );

    assign exec_err = op_is_err(op_q);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        id_d        = id_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (|gnt) begin
                    if (gnt[1]) begin
                        a_d  = bus.req1_a;
                        b_d  = bus.req1_b;
                        op_d = bus.req1_op;
                        id_d = 1'b1;
                    end else begin
                        a_d  = bus.req0_a;
                        b_d  = bus.req0_b;
                        op_d = bus.req0_op;
                        id_d = 1'b0;
                    end
                    state_d = StExec;
                end
            end
            StExec: begin
                // Unsupported codes return a clean zero result rather than ALU garbage.
                rsp_id_d    = id_q;
                rsp_err_d   = exec_err;
                rsp_data_d  = exec_err ? '0 : alu_out;
                rsp_carry_d = !exec_err && carry_out && (op_q == ALU_ADD);
                state_d     = StResp;
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    rr_ptr_d = ~rsp_id_q;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= StIdle;
            rr_ptr_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            id_q        <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            id_q        <= id_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];
    assign bus.rsp_valid  = (state_q == StResp);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_carry  = rsp_carry_q;
    assign bus.rsp_err    = rsp_err_q;

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_select = op_q;
    assign busy       = (state_q != StIdle);
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Scoreboard bench for alu_scheduler: random and directed ops, external ALU model,
// reference results computed with plain integer arithmetic.
module tb_alu_scheduler;
    import alu_scheduler_pkg::*;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
    } op_t;

    typedef struct {
        logic       id;
        logic [3:0] data;
        logic       carry;
        logic       err;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic [3:0] alu_a, alu_b, alu_out;
    logic [2:0] alu_select;
    logic       carry_out, busy;
    logic [7:0] op_count;

    alu_scheduler_if #(.DATA_W(4)) bus ();

    alu_scheduler #(.DATA_W(4), .CNT_W(8)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_select (alu_select),
        .alu_out    (alu_out),
        .carry_out  (carry_out),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External ALU; carry is the raw adder carry for every op, bad codes give junk.
    always_comb begin
        logic [4:0] sum;
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        carry_out = sum[4];
        case (alu_select)
            3'd0:    alu_out = alu_a & alu_b;
            3'd1:    alu_out = alu_a | alu_b;
            3'd2:    alu_out = alu_a ^ alu_b;
            3'd3:    alu_out = sum[3:0];
            3'd4:    alu_out = ~alu_a;
            3'd5:    alu_out = alu_a - alu_b;
            default: alu_out = sum[3:0] ^ 4'hA;
        endcase
    end

    int         total = 0;
    int         bad = 0;
    int         rdy_pct = 100;
    logic       prio = 1'b0;
    logic [7:0] exp_count = 8'd0;
    op_t        q0[$];
    op_t        q1[$];
    exp_t       sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input logic id, input op_t o, input int acc);
        exp_t e;
        int   a, b, r;
        a = int'(o.a);
        b = int'(o.b);
        r = 0;
        e.id = id;
        e.carry = 1'b0;
        e.err = 1'b0;
        e.acc = acc;
        case (o.op)
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_ADD: begin
                r = a + b;
                e.carry = (r >= 16);
            end
            ALU_NOT: r = 15 - a;
            ALU_SUB: r = a - b + 16;
            default: begin
                e.err = 1'b1;
                r = 0;
            end
        endcase
        e.data = 4'(r % 16);
        return e;
    endfunction

    function automatic op_t mk(input int a, input int b, input int op);
        op_t o;
        o.a = 4'(a);
        o.b = 4'(b);
        o.op = 3'(op);
        return o;
    endfunction

    // Requester drivers: present queued ops, record expectation at acceptance.
    initial begin : req_drv
        op_t  o;
        logic id, eg, acc0, acc1;
        acc0 = 1'b0;
        acc1 = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        forever begin
            @(negedge clk);
            if (!reset_L) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
                acc0 = 1'b0;
                acc1 = 1'b0;
            end else begin
                if (acc0) begin bus.req0_valid = 1'b0; acc0 = 1'b0; end
                if (acc1) begin bus.req1_valid = 1'b0; acc1 = 1'b0; end
                if (!bus.req0_valid && q0.size() > 0) begin
                    o = q0.pop_front();
                    bus.req0_a = o.a; bus.req0_b = o.b; bus.req0_op = o.op;
                    bus.req0_valid = 1'b1;
                end
                if (!bus.req1_valid && q1.size() > 0) begin
                    o = q1.pop_front();
                    bus.req1_a = o.a; bus.req1_b = o.b; bus.req1_op = o.op;
                    bus.req1_valid = 1'b1;
                end
                #1;
                if (bus.req0_ready || bus.req1_ready) begin
                    id = bus.req1_ready;
                    eg = (bus.req0_valid && bus.req1_valid) ? prio : bus.req1_valid;
                    chk("grant_id", id, eg);
                    o = id ? {bus.req1_a, bus.req1_b, bus.req1_op}
                           : {bus.req0_a, bus.req0_b, bus.req0_op};
                    sb.push_back(model(id, o, cyc));
                    prio = ~id;
                    if (id) acc1 = 1'b1; else acc0 = 1'b1;
                end
            end
        end
    end

    initial begin : rdy_drv
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.rsp_ready = ($urandom_range(99) < rdy_pct);
        end
    end

    // Monitor: compare each new response with the scoreboard, check holds and drops.
    initial begin : mon
        exp_t       e;
        logic       pv, pr, pid, pcarry, perr;
        logic [3:0] pdata;
        pv = 1'b0; pr = 1'b0; pid = 1'b0; pcarry = 1'b0; perr = 1'b0; pdata = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset_L) begin
                pv = 1'b0;
                pr = 1'b0;
            end else begin
                if (bus.req0_ready || bus.req1_ready)
                    chk("ready_onehot", bus.req0_ready & bus.req1_ready, 1'b0);
                if (pv && pr) chk("rsp_drop", bus.rsp_valid, 1'b0);
                if (bus.rsp_valid) begin
                    if (pv && !pr) begin
                        chk("hold_id", bus.rsp_id, pid);
                        chk("hold_data", bus.rsp_data, pdata);
                        chk("hold_carry", bus.rsp_carry, pcarry);
                        chk("hold_err", bus.rsp_err, perr);
                        chk("hold_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
                    end else if (sb.size() == 0) begin
                        chk("unexpected_rsp", 1'b1, 1'b0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_id", bus.rsp_id, e.id);
                        chk("rsp_data", bus.rsp_data, e.data);
                        chk("rsp_carry", bus.rsp_carry, e.carry);
                        chk("rsp_err", bus.rsp_err, e.err);
                        chk("rsp_latency", cyc - e.acc, 2);
                        chk("op_count", op_count, exp_count);
                    end
                    if (bus.rsp_ready) exp_count = exp_count + 8'd1;
                end
                pv = bus.rsp_valid; pr = bus.rsp_ready; pid = bus.rsp_id;
                pdata = bus.rsp_data; pcarry = bus.rsp_carry; perr = bus.rsp_err;
            end
        end
    end

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #3;
            n++;
        end while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0 || bus.req0_valid ||
                    bus.req1_valid || busy) && n < 20000);
        chk(nm, n < 20000, 1'b1);
    endtask

    initial begin : main
        op_t o;
        int  n;
        repeat (3) @(negedge clk);
        #4;
        chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_op_count", op_count, 8'd0);
        chk("reset_alu", {alu_a, alu_b, alu_select}, 11'd0);
        chk("reset_rsp", {bus.rsp_id, bus.rsp_data, bus.rsp_carry, bus.rsp_err}, 7'd0);
        reset_L = 1'b1;

        // Contention from reset: grants must alternate 0,1,0,1.
        for (int i = 0; i < 2; i++) begin
            q0.push_back(mk($urandom_range(15), $urandom_range(15), 0));
            q1.push_back(mk($urandom_range(15), $urandom_range(15), 0));
        end
        wait_idle("t2_done");
        chk("t2_count", op_count, 8'd4);

        q0.push_back(mk(9, 8, 3));
        wait_idle("t1_done");
        chk("t1_count", op_count, 8'd5);
        chk("t1_last", {bus.rsp_id, bus.rsp_data, bus.rsp_carry}, {1'b0, 4'h1, 1'b1});

        q1.push_back(mk(5, 3, 6));
        q0.push_back(mk(5, 3, 2));
        wait_idle("t3_done");
        chk("t3_last", {bus.rsp_id, bus.rsp_data, bus.rsp_err}, {1'b0, 4'h6, 1'b0});

        rdy_pct = 0;
        q0.push_back(mk(12, 3, 5));
        n = 0;
        do begin @(negedge clk); #3; n++; end while (!bus.rsp_valid && n < 50);
        chk("t4_valid_seen", bus.rsp_valid, 1'b1);
        repeat (5) @(negedge clk);
        rdy_pct = 100;
        wait_idle("t4_done");
        chk("t4_count", op_count, 8'd8);

        // Reset while the op is in EXEC: no response, priority back to req0.
        q0.push_back(mk(7, 9, 1));
        n = 0;
        do begin @(negedge clk); #3; n++; end while (!(busy && !bus.rsp_valid) && n < 50);
        chk("t5_exec_seen", busy, 1'b1);
        reset_L = 1'b0;
        #1;
        chk("t5_busy", busy, 1'b0);
        chk("t5_rsp_valid", bus.rsp_valid, 1'b0);
        chk("t5_alu", {alu_a, alu_b, alu_select}, 11'd0);
        chk("t5_count", op_count, 8'd0);
        sb.delete();
        q0.delete();
        q1.delete();
        prio = 1'b0;
        exp_count = 8'd0;
        repeat (2) @(negedge clk);
        #3;
        reset_L = 1'b1;
        q0.push_back(mk(1, 2, 0));
        q1.push_back(mk(3, 4, 0));
        wait_idle("t5_done");

        rdy_pct = 70;
        q0.push_back(mk(2, 5, 5));
        wait_idle("t6_sub_done");
        chk("t6_sub", {bus.rsp_data, bus.rsp_carry, bus.rsp_err}, {4'hD, 1'b0, 1'b0});
        for (int i = 0; i < 258; i++) begin
            o = mk($urandom_range(15), $urandom_range(15), $urandom_range(7));
            if ($urandom_range(1) == 0) q0.push_back(o);
            else q1.push_back(o);
        end
        wait_idle("t6_done");
        chk("t6_wrap_count", op_count, 8'd5);
        chk("final_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
